// File: rtl/fifo_byte_packer.sv
// Packs a byte stream into 36-bit FIFO words of four {valid, byte} lanes.
// Partial words flush on in_last or after TIMEOUT idle cycles; one holding register absorbs full.
module fifo_byte_packer #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [35:0]      fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    output logic [CNT_W-1:0] words_written
);

    localparam int unsigned TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    logic [26:0]      acc_q, acc_d;
    logic [1:0]       idx_q, idx_d;
    logic [35:0]      pend_q, pend_d;
    logic             pend_flag_q, pend_flag_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        wr_en;
    logic        space;
    logic        accept;
    logic        tmr_hit;
    logic        flush;
    logic [4:0]  lane_shift;
    logic [35:0] lane_ins;

    always_comb begin
        wr_en      = pend_flag_q & ~fifo_full & ~rst;
        // The holding register is free if empty or being drained this cycle.
        space      = ~pend_flag_q | wr_en;
        accept     = in_valid & space & ~rst;
        tmr_hit    = (TIMEOUT != 0) && (tmr_q == TMR_MAX);
        flush      = ~accept & (idx_q != 2'd0) & tmr_hit & space & ~rst;
        lane_shift = 5'(idx_q) * 5'd9;
        lane_ins   = {9'b0, acc_q} | ({27'b0, 1'b1, in_data} << lane_shift);
    end

    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q & ~wr_en;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;

        if (wr_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept) begin
            tmr_d = '0;
            if ((idx_q == 2'd3) || in_last) begin
                pend_d      = lane_ins;
                pend_flag_d = 1'b1;
                idx_d       = 2'd0;
                acc_d       = '0;
            end else begin
                acc_d = lane_ins[26:0];
                idx_d = idx_q + 2'd1;
            end
        end else if (flush) begin
            pend_d      = {9'b0, acc_q};
            pend_flag_d = 1'b1;
            idx_d       = 2'd0;
            acc_d       = '0;
            tmr_d       = '0;
        end else if (idx_q == 2'd0) begin
            tmr_d = '0;
        end else if (tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            tmr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready      = space & ~rst;
    assign fifo_wr_en    = wr_en;
    assign fifo_din      = pend_q;
    assign words_written = cnt_q;

endmodule
